// File: rtl/mod_writeback_unit.sv
// rtl/mod_writeback_unit.sv - writeback stage: register file, stack-pointer updates, store hold, scoreboard
module mod_writeback_unit #(
  parameter int DATA_W     = 64,
  parameter int NUM_REGS   = 16,
  parameter int SP_IDX     = 4,
  parameter int STACK_STEP = 8,
  parameter int NUM_RD     = 2,
  parameter int CNT_W      = 32,
  parameter int RIDX_W     = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [2:0]                 wb_kind,
  input  logic [RIDX_W-1:0]          wb_dst0,
  input  logic [RIDX_W-1:0]          wb_dst1,
  input  logic [DATA_W-1:0]          wb_data0,
  input  logic [DATA_W-1:0]          wb_data1,
  input  logic                       wb_sim_end,
  input  logic                       store_done,
  input  logic [NUM_RD*RIDX_W-1:0]   rd_idx,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       sb_set_valid,
  input  logic [RIDX_W-1:0]          sb_set_idx,
  output logic [NUM_REGS-1:0]        sb_busy,
  output logic                       store_wb_flag,
  output logic                       halted,
  output logic [CNT_W-1:0]           retire_count
);

  localparam logic [2:0] K_WR1   = 3'd1;
  localparam logic [2:0] K_WR2   = 3'd2;
  localparam logic [2:0] K_PUSH  = 3'd3;
  localparam logic [2:0] K_POP   = 3'd4;
  localparam logic [2:0] K_STORE = 3'd5;

  typedef enum logic [1:0] {IDLE, WAIT_ST, HALT} state_t;

  state_t              state;
  logic                halt_pend;
  logic [DATA_W-1:0]   regs      [NUM_REGS];
  logic [DATA_W-1:0]   next_regs [NUM_REGS];
  logic [NUM_REGS-1:0] wr_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic                accept;
  logic                we0;
  logic                we1;
  logic                sp_we;
  logic [DATA_W-1:0]   sp_new;
  logic                is_retire;

  assign wb_ready  = (state == IDLE) & reset_n;
  assign accept    = wb_valid & wb_ready;
  assign is_retire = (wb_kind != 3'd0) && (wb_kind <= K_STORE);

  // next_regs is both the write-back value and the bypass source for the read ports;
  // later assignments win: SP adjust, then dst0, then dst1.
  always_comb begin
    we0    = accept && (wb_kind == K_WR1 || wb_kind == K_WR2 || wb_kind == K_POP);
    we1    = accept && (wb_kind == K_WR2);
    sp_we  = accept && (wb_kind == K_PUSH || wb_kind == K_POP);
    sp_new = (wb_kind == K_PUSH) ? regs[SP_IDX] - DATA_W'(STACK_STEP)
                                 : regs[SP_IDX] + DATA_W'(STACK_STEP);
    wr_mask  = '0;
    set_mask = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      next_regs[i] = regs[i];
      if (sp_we && i == SP_IDX) begin
        next_regs[i] = sp_new;
        wr_mask[i]   = 1'b1;
      end
      if (we0 && wb_dst0 == RIDX_W'(i)) begin
        next_regs[i] = wb_data0;
        wr_mask[i]   = 1'b1;
      end
      if (we1 && wb_dst1 == RIDX_W'(i)) begin
        next_regs[i] = wb_data1;
        wr_mask[i]   = 1'b1;
      end
      if (sb_set_valid && sb_set_idx == RIDX_W'(i))
        set_mask[i] = 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++)
      rd_data[k*DATA_W +: DATA_W] = next_regs[rd_idx[k*RIDX_W +: RIDX_W]];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      halt_pend     <= 1'b0;
      sb_busy       <= '0;
      store_wb_flag <= 1'b0;
      halted        <= 1'b0;
      retire_count  <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      store_wb_flag <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= next_regs[i];
      sb_busy <= (sb_busy & ~wr_mask) | set_mask;

      case (state)
        IDLE: begin
          if (accept) begin
            if (is_retire && !(&retire_count))
              retire_count <= retire_count + CNT_W'(1);
            if (wb_kind == K_STORE && !store_done) begin
              state     <= WAIT_ST;
              halt_pend <= wb_sim_end;
            end else begin
              if (wb_kind == K_PUSH || wb_kind == K_STORE)
                store_wb_flag <= 1'b1;
              if (wb_sim_end) begin
                state  <= HALT;
                halted <= 1'b1;
              end
            end
          end
        end
        WAIT_ST: begin
          if (store_done) begin
            store_wb_flag <= 1'b1;
            if (halt_pend) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule
